// File: rtl/rcpu_io_uart.sv
// Memory-mapped 8N1 UART on the CPU SYS I/O bus: DATA/STATUS/DIV registers,
// TX and RX FIFOs, and a programmable clocks-per-bit divisor.
module rcpu_io_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] ADDR_DATA   = BASE_ADDR;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd4;
  localparam logic [15:0] ADDR_DIV    = BASE_ADDR + 16'd8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [15:0] div_r, eff_div_s, rd_data_r, rd_mux_s, status_s;
  logic        txovf_r, rxovr_r, frameerr_r;
  logic        sel_data_s, sel_status_s, sel_div_s;
  logic        wr_data_s, wr_div_s, rd_data_sel_s, rd_status_s;

  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wr_ptr_r, tx_rd_ptr_r;
  logic        tx_empty_s, tx_full_s, tx_push_s, tx_pop_s, txovf_set_s;
  logic [1:0]  tx_state_r;
  logic [15:0] tx_cnt_r, tx_div_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        tx_line_r, tx_bit_end_s, tx_idle_s;

  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] rx_wr_ptr_r, rx_rd_ptr_r;
  logic        rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;
  logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
  logic [1:0]  rx_state_r;
  logic [15:0] rx_cnt_r, rx_div_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_bit_end_s, rx_half_end_s, rx_stop_s, rx_stop_ok_s;
  logic        rxovr_set_s, frameerr_set_s;

  assign sel_data_s    = (io_address == ADDR_DATA);
  assign sel_status_s  = (io_address == ADDR_STATUS);
  assign sel_div_s     = (io_address == ADDR_DIV);
  assign wr_data_s     = io_write_enable & sel_data_s;
  assign wr_div_s      = io_write_enable & sel_div_s;
  assign rd_data_sel_s = io_read_enable & sel_data_s;
  assign rd_status_s   = io_read_enable & sel_status_s;
  assign eff_div_s     = (div_r < 16'd4) ? 16'd4 : div_r;

  assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
  assign tx_full_s  = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                      (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
  assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
  assign rx_full_s  = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                      (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);

  // A pop on the same edge frees a slot, so a push into a full FIFO is then accepted.
  assign tx_bit_end_s = (tx_cnt_r == tx_div_r - 16'd1);
  assign tx_pop_s     = ~tx_empty_s & ((tx_state_r == ST_IDLE) |
                                       ((tx_state_r == ST_STOP) & tx_bit_end_s));
  assign tx_push_s    = wr_data_s & (~tx_full_s | tx_pop_s);
  assign txovf_set_s  = wr_data_s & tx_full_s & ~tx_pop_s;
  assign tx_idle_s    = (tx_state_r == ST_IDLE) & tx_empty_s;

  assign rx_fall_s      = rx_prev_r & ~rx_sync_r;
  assign rx_bit_end_s   = (rx_cnt_r == rx_div_r - 16'd1);
  assign rx_half_end_s  = (rx_cnt_r == (rx_div_r >> 1) - 16'd1);
  assign rx_stop_s      = (rx_state_r == ST_STOP) & rx_bit_end_s;
  assign rx_stop_ok_s   = rx_stop_s & rx_sync_r;
  assign frameerr_set_s = rx_stop_s & ~rx_sync_r;
  assign rx_pop_s       = rd_data_sel_s & ~rx_empty_s;
  assign rx_push_s      = rx_stop_ok_s & (~rx_full_s | rx_pop_s);
  assign rxovr_set_s    = rx_stop_ok_s & rx_full_s & ~rx_pop_s;

  assign status_s = {10'd0, txovf_r, frameerr_r, rxovr_r, tx_idle_s, tx_full_s, ~rx_empty_s};

  // Read-data multiplexer; status and DIV reflect the state before this edge.
  always_comb begin
    rd_mux_s = 16'h0000;
    if (sel_data_s) begin
      if (!rx_empty_s) begin
        rd_mux_s = {7'd0, 1'b1, rx_mem_r[rx_rd_ptr_r[AW-1:0]]};
      end else begin
        rd_mux_s = 16'h0000;
      end
    end else if (sel_status_s) begin
      rd_mux_s = status_s;
    end else if (sel_div_s) begin
      rd_mux_s = div_r;
    end else begin
      rd_mux_s = 16'h0000;
    end
  end

  // Bus-facing registers: read data, divisor and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r  <= 16'h0000;
      div_r      <= DEFAULT_DIV;
      txovf_r    <= 1'b0;
      rxovr_r    <= 1'b0;
      frameerr_r <= 1'b0;
    end else begin
      if (io_read_enable) rd_data_r <= rd_mux_s;
      if (wr_div_s) div_r <= io_write_data;
      txovf_r    <= txovf_set_s    | (txovf_r    & ~rd_status_s);
      rxovr_r    <= rxovr_set_s    | (rxovr_r    & ~rd_status_s);
      frameerr_r <= frameerr_set_s | (frameerr_r & ~rd_status_s);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= io_write_data[7:0];
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_shift_r;
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
    end
  end

  // TX framing FSM; the line level is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_div_r   <= 16'd4;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_line_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          tx_line_r <= 1'b1;
          if (tx_pop_s) begin
            tx_shift_r <= tx_mem_r[tx_rd_ptr_r[AW-1:0]];
            tx_div_r   <= eff_div_s;
            tx_cnt_r   <= 16'd0;
            tx_line_r  <= 1'b0;
            tx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (tx_bit_end_s) begin
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= tx_shift_r[0];
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_bit_end_s) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 3'd7) begin
              tx_line_r  <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_line_r  <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_bit_end_s) begin
            tx_cnt_r <= 16'd0;
            if (tx_pop_s) begin
              tx_shift_r <= tx_mem_r[tx_rd_ptr_r[AW-1:0]];
              tx_div_r   <= eff_div_s;
              tx_line_r  <= 1'b0;
              tx_state_r <= ST_START;
            end else begin
              tx_state_r <= ST_IDLE;
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= ST_IDLE;
          tx_line_r  <= 1'b1;
        end
      endcase
    end
  end

  // RX line synchronizer and previous-level tracker for start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX framing FSM; the start bit is re-checked half a bit in to reject glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_div_r   <= 16'd4;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        ST_IDLE: begin
          if (rx_fall_s) begin
            rx_div_r   <= eff_div_s;
            rx_cnt_r   <= 16'd0;
            rx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (rx_half_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_bit_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= ST_STOP;
            end else begin
              rx_bit_r <= rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_bit_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= ST_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: begin
          rx_state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_read_data = rd_data_r;
  assign uart_tx      = tx_line_r;

endmodule

// File: tb/tb_rcpu_io_uart.sv
// Directed bench for rcpu_io_uart: register reads, TX framing, RX reception,
// FIFO overflow, sticky flags, mid-frame reset and glitch rejection.
module tb_rcpu_io_uart;

  localparam logic [15:0] A_DATA   = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0004;
  localparam logic [15:0] A_DIV    = 16'h0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = 16'h0000;
  logic [15:0] io_write_data = 16'h0000;
  logic [15:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  rcpu_io_uart #(.BASE_ADDR(16'h0000), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd104)) dut (
    .clk(clk), .reset(reset),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_read_enable = 1'b1;
    io_address = a;
    @(negedge clk);
    io_read_enable = 1'b0;
    d = io_read_data;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_write_enable = 1'b1;
    io_address = a;
    io_write_data = d;
    @(negedge clk);
    io_write_enable = 1'b0;
  endtask

  task automatic read_expect(input logic [15:0] a, input logic [15:0] exp, input string name);
    logic [15:0] d;
    bus_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, d, exp);
    end
  endtask

  task automatic wait_tx_low(input int budget, input string name);
    int k = 0;
    while (uart_tx !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL %s: no start bit within %0d cycles, uart_tx=%b expected 0", name, budget, uart_tx);
    end
  endtask

  // Entered on the first start-bit cycle; leaves on the first cycle after the stop bit.
  task automatic check_tx_frame(input logic [7:0] b, input int div, input string name);
    logic [9:0] f;
    logic ok;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ok = 1'b1;
      for (int j = 0; j < div; j++) begin
        if (uart_tx !== f[i]) ok = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s bit %0d: uart_tx not held at %b for %0d cycles", name, i, f[i], div);
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (div) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (uart_tx !== 1'b1 || io_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: uart_tx=%b rdata=%h expected 1 and 0000", uart_tx, io_read_data);
    end
    read_expect(A_STATUS, 16'h0004, "reset_status");
    read_expect(A_DIV, 16'd104, "reset_div");
    read_expect(16'h000C, 16'h0000, "unmapped_read");
  endtask

  task automatic test_tx();
    bus_write(A_DIV, 16'd16);
    bus_write(A_DATA, 16'h00A5);
    wait_tx_low(2, "tx_start_latency");
    check_tx_frame(8'hA5, 16, "tx_a5");
    read_expect(A_STATUS, 16'h0004, "tx_status_after");
  endtask

  task automatic test_rx();
    send_rx(8'h3C, 16, 1'b1);
    read_expect(A_STATUS, 16'h0005, "rx_status_avail");
    read_expect(A_DATA, 16'h013C, "rx_data");
    read_expect(A_DATA, 16'h0000, "rx_data_empty");
    read_expect(A_STATUS, 16'h0004, "rx_status_empty");
  endtask

  task automatic test_rx_overrun();
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 16, 1'b1);
    // RX FIFO still holds 8 bytes and TX is idle, so RX_AVAIL and TX_IDLE accompany RXOVR.
    read_expect(A_STATUS, 16'h000D, "rxovr_set");
    read_expect(A_STATUS, 16'h0005, "rxovr_cleared");
    for (int i = 1; i <= 8; i++) read_expect(A_DATA, 16'h0100 | 16'(i), "rx_fifo_order");
    read_expect(A_DATA, 16'h0000, "rx_fifo_drained");
  endtask

  task automatic test_back_to_back();
    logic ok;
    fork
      begin
        @(negedge clk);
        io_write_enable = 1'b1;
        io_address = A_DATA;
        io_write_data = 16'h0010;
        for (int i = 1; i <= 9; i++) begin
          @(negedge clk);
          io_write_data = 16'h0010 + 16'(i);
        end
        @(negedge clk);
        io_write_enable = 1'b0;
      end
      begin
        wait_tx_low(6, "b2b_first_start");
        for (int k = 0; k < 9; k++) check_tx_frame(8'h10 + 8'(k), 16, "b2b_frame");
      end
    join
    ok = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (uart_tx !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_no_tenth_frame: uart_tx left idle, expected 1");
    end
    read_expect(A_STATUS, 16'h0024, "txovf_set");
    read_expect(A_STATUS, 16'h0004, "txovf_cleared");
  endtask

  task automatic test_frame_error();
    send_rx(8'h55, 16, 1'b0);
    read_expect(A_STATUS, 16'h0014, "frameerr_set");
    read_expect(A_DATA, 16'h0000, "frameerr_no_push");
    read_expect(A_STATUS, 16'h0004, "frameerr_cleared");
  endtask

  task automatic test_div_min();
    logic [15:0] d;
    bus_write(A_DIV, 16'd2);
    read_expect(A_DIV, 16'd2, "div_stored_raw");
    bus_write(A_DATA, 16'h005A);
    wait_tx_low(2, "div_min_start");
    check_tx_frame(8'h5A, 4, "div_min_frame");
    @(negedge clk);
    io_read_enable = 1'b1;
    io_write_enable = 1'b1;
    io_address = A_DIV;
    io_write_data = 16'd16;
    @(negedge clk);
    io_read_enable = 1'b0;
    io_write_enable = 1'b0;
    d = io_read_data;
    checks++;
    if (d !== 16'd2) begin
      errors++;
      $display("FAIL div_rw_prewrite: got %h expected 0002", d);
    end
    bus_write(A_DIV, 16'd16);
    checks++;
    if (io_read_data !== 16'd2) begin
      errors++;
      $display("FAIL rdata_held: got %h expected 0002", io_read_data);
    end
    read_expect(A_DIV, 16'd16, "div_after_rw");
  endtask

  task automatic test_reset_mid_tx();
    bus_write(A_DATA, 16'h0000);
    bus_write(A_DATA, 16'h0000);
    wait_tx_low(4, "mid_tx_start");
    repeat (16 * 4 + 8) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_tx_bit3: uart_tx=%b expected 0", uart_tx);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort_tx: uart_tx=%b expected 1", uart_tx);
    end
    reset = 1'b0;
    read_expect(A_STATUS, 16'h0004, "reset_mid_status");
    read_expect(A_DIV, 16'd104, "reset_mid_div");
  endtask

  task automatic test_glitch();
    bus_write(A_DIV, 16'd16);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    read_expect(A_STATUS, 16'h0004, "glitch_status");
    read_expect(A_DATA, 16'h0000, "glitch_no_push");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_rx_overrun();
    test_back_to_back();
    test_frame_error();
    test_div_min();
    test_reset_mid_tx();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
